// File: rtl/hazard_sched_ctrl.sv
// Hazard controller for the 5-stage core: EX forwarding, load-use and mult/div stalls, redirect flush, and mult/div sequencing.
// Optional HAZARD_PERF_EN adds the stall_cycles / flush_count performance counters.
module hazard_sched_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_md_req,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_md_op,
  input  logic                  ex_redirect,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_read,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  pc_write_en,
  output logic                  ifid_write_en,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  md_start,
  output logic                  md_busy,
  output logic                  md_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
`endif
);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

  md_state_t  md_state, md_state_n;
  logic [3:0] md_cnt, md_cnt_n;
  logic       md_accept;
  logic       load_use;
  logic       md_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
    end else begin
      md_state <= md_state_n;
      md_cnt   <= md_cnt_n;
    end
  end

  // Handshake: md_start is a one-cycle request taken only from IDLE or DONE; md_done is the one-cycle completion pulse.
  always_comb begin
    md_state_n = md_state;
    md_cnt_n   = md_cnt;
    md_accept  = 1'b0;
    case (md_state)
      MD_IDLE, MD_DONE: begin
        md_state_n = MD_IDLE;
        if (ex_md_op) begin
          md_accept  = 1'b1;
          md_state_n = MD_BUSY;
          md_cnt_n   = MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (md_cnt == 4'd0) md_state_n = MD_DONE;
        else                md_cnt_n   = md_cnt - 4'd1;
      end
      default: md_state_n = MD_IDLE;
    endcase
  end

  assign md_busy = (md_state == MD_BUSY);
  assign md_done = (md_state == MD_DONE);

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
    if (mem_reg_write && !mem_mem_read && (mem_rd == src)) return 2'b10;
    else if (wb_reg_write && (wb_rd == src))               return 2'b01;
    else                                                    return 2'b00;
  endfunction

  assign load_use = ex_mem_read && ex_reg_write &&
                    ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  assign md_stall = id_md_req && (md_state == MD_BUSY);

  always_comb begin
    fwd_a         = fwd_sel(ex_rs);
    fwd_b         = fwd_sel(ex_rt);
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    md_start      = md_accept;
    if (load_use || md_stall) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_bubble   = 1'b1;
    end
    // The stalled ID instruction is killed by the redirect, so the redirect wins.
    if (ex_redirect) begin
      pc_write_en   = 1'b1;
      ifid_write_en = 1'b1;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
    end
    if (!rst_n) begin
      fwd_a         = 2'b00;
      fwd_b         = 2'b00;
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      md_start      = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write_en) stall_cycles <= stall_cycles + 32'd1;
      if (ex_redirect)  flush_count  <= flush_count + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  md_op_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(md_state == MD_BUSY && ex_md_op))
    else $error("ex_md_op asserted while mult/div unit is busy");
`endif

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Self-checking bench for hazard_sched_ctrl: directed test-plan scenarios plus randomized cycles against a reference model.
module tb_hazard_sched_ctrl;
  localparam int W   = 5;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic         id_uses_rs, id_uses_rt, id_md_req;
  logic         ex_reg_write, ex_mem_read, ex_md_op, ex_redirect;
  logic         mem_reg_write, mem_mem_read, wb_reg_write;
  logic [1:0]   fwd_a, fwd_b;
  logic         pc_write_en, ifid_write_en, ifid_flush, idex_bubble;
  logic         md_start, md_busy, md_done;
`ifdef HAZARD_PERF_EN
  logic [31:0]  stall_cycles, flush_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: cycles of BUSY still ahead, and whether a done pulse is due
  int m_busy_left = 0;
  bit m_done      = 1'b0;

  logic [10:0] obs;
  assign obs = {fwd_a, fwd_b, pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
                md_start, md_busy, md_done};

  always #5 clk = ~clk;

  hazard_sched_ctrl #(.REG_ADDR_W(W), .MD_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_md_req(id_md_req),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_md_op(ex_md_op), .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .md_start(md_start), .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  function automatic logic [1:0] ref_fwd(input logic [W-1:0] src);
    if (mem_reg_write && !mem_mem_read && mem_rd == src) return 2'd2;
    if (wb_reg_write && wb_rd == src)                    return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [10:0] exp_vec();
    logic [1:0] fa, fb;
    logic lu, st, pc, ifw, fl, bub, ms;
    fa  = ref_fwd(ex_rs);
    fb  = ref_fwd(ex_rt);
    lu  = ex_mem_read && ex_reg_write &&
          ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    st  = lu || (id_md_req && m_busy_left > 0);
    ms  = ex_md_op && m_busy_left == 0;
    pc  = !st; ifw = !st; fl = 1'b0; bub = st;
    if (ex_redirect) begin pc = 1'b1; ifw = 1'b1; fl = 1'b1; bub = 1'b1; end
    if (!rst_n) begin fa = 2'd0; fb = 2'd0; pc = 1'b0; ifw = 1'b0; fl = 1'b1; bub = 1'b1; ms = 1'b0; end
    return {fa, fb, pc, ifw, fl, bub, ms, (m_busy_left > 0), m_done};
  endfunction

  // advance the model across the rising edge using the inputs held during the cycle
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_busy_left = 0;
      m_done      = 1'b0;
    end else begin
      m_done = (m_busy_left == 1);
      if (ex_md_op && m_busy_left == 0) m_busy_left = LAT;
      else if (m_busy_left > 0)         m_busy_left--;
    end
  endtask

  task automatic drive_idle();
    @(negedge clk);
    id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_md_req = 1'b0;
    ex_rs = 5'd1; ex_rt = 5'd2; ex_rd = 5'd7; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    ex_md_op = 1'b0; ex_redirect = 1'b0;
    mem_rd = 5'd9; mem_reg_write = 1'b0; mem_mem_read = 1'b0;
    wb_rd = 5'd10; wb_reg_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    ex_redirect = 1'b1; mem_reg_write = 1'b1; mem_rd = ex_rs; ex_md_op = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 11'b00_00_0011_0_0_0 && obs !== {9'b00_00_0011_0, 2'b00}) begin
      n_fail++; $display("FAIL reset_forced: got %b want %b", obs, 11'b00000011000);
    end
    tick();
    #1;
    n_cmp++;
    if ({md_busy, md_done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_md_regs: got %b want 00", {md_busy, md_done});
    end
    drive_idle();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_release: got %b want %b", obs, exp_vec()); end
    tick();
  endtask

  task automatic test_forwarding();
    drive_idle();
    mem_reg_write = 1'b1; mem_rd = 5'd3; wb_reg_write = 1'b1; wb_rd = 5'd3; ex_rs = 5'd3; ex_rt = 5'd4;
    #1;
    n_cmp++;
    if ({fwd_a, fwd_b} !== 4'b10_00) begin n_fail++; $display("FAIL fwd_exmem: got %b want 1000", {fwd_a, fwd_b}); end
    tick();
    drive_idle();
    mem_reg_write = 1'b1; mem_rd = 5'd3; mem_mem_read = 1'b1; wb_reg_write = 1'b1; wb_rd = 5'd3;
    ex_rs = 5'd3; ex_rt = 5'd4;
    #1;
    n_cmp++;
    if ({fwd_a, fwd_b} !== 4'b01_00) begin n_fail++; $display("FAIL fwd_load_memwb: got %b want 0100", {fwd_a, fwd_b}); end
    tick();
    drive_idle();
    mem_reg_write = 1'b1; mem_rd = 5'd0; wb_reg_write = 1'b1; wb_rd = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
    #1;
    n_cmp++;
    if ({fwd_a, fwd_b} !== 4'b10_10) begin n_fail++; $display("FAIL fwd_reg0: got %b want 1010", {fwd_a, fwd_b}); end
    tick();
    for (int i = 0; i < 40; i++) begin
      drive_idle();
      ex_rs = W'($urandom_range(0, 3)); ex_rt = W'($urandom_range(0, 3));
      mem_rd = W'($urandom_range(0, 3)); wb_rd = W'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom); mem_mem_read = 1'($urandom); wb_reg_write = 1'($urandom);
      #1;
      n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL fwd_random[%0d]: got %b want %b", i, obs, exp_vec()); end
      tick();
    end
  endtask

  task automatic test_load_use();
    drive_idle();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5; id_uses_rt = 1'b1; id_rt = 5'd5;
    #1;
    n_cmp++;
    if ({pc_write_en, ifid_write_en, idex_bubble, ifid_flush} !== 4'b0010) begin
      n_fail++; $display("FAIL load_use_stall: got %b want 0010", {pc_write_en, ifid_write_en, idex_bubble, ifid_flush});
    end
    tick();
    drive_idle();
    id_uses_rt = 1'b1; id_rt = 5'd5; ex_rd = 5'd5; ex_reg_write = 1'b1;
    #1;
    n_cmp++;
    if ({pc_write_en, ifid_write_en, idex_bubble, ifid_flush} !== 4'b1100) begin
      n_fail++; $display("FAIL load_use_resume: got %b want 1100", {pc_write_en, ifid_write_en, idex_bubble, ifid_flush});
    end
    tick();
  endtask

  task automatic test_md_sequence();
    int busy_cnt = 0;
    int done_at  = -1;
    drive_idle();
    ex_md_op = 1'b1;
    #1;
    n_cmp++;
    if (md_start !== 1'b1) begin n_fail++; $display("FAIL md_start: got %b want 1", md_start); end
    tick();
    for (int c = 1; c <= LAT + 2; c++) begin
      drive_idle();
      id_md_req = 1'b1;
      #1;
      n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL md_cycle[%0d]: got %b want %b", c, obs, exp_vec()); end
      if (md_busy && !pc_write_en) busy_cnt++;
      if (md_done && done_at < 0) done_at = c;
      tick();
    end
    n_cmp++;
    if (busy_cnt !== LAT) begin n_fail++; $display("FAIL md_busy_len: got %0d want %0d", busy_cnt, LAT); end
    n_cmp++;
    if (done_at !== LAT + 1) begin n_fail++; $display("FAIL md_done_cycle: got %0d want %0d", done_at, LAT + 1); end
  endtask

  task automatic test_back_to_back();
    drive_idle(); ex_md_op = 1'b1; tick();
    for (int c = 0; c < LAT; c++) begin drive_idle(); tick(); end
    drive_idle(); ex_md_op = 1'b1;
    #1;
    n_cmp++;
    if ({md_done, md_start} !== 2'b11) begin n_fail++; $display("FAIL done_to_busy: got %b want 11", {md_done, md_start}); end
    tick();
    drive_idle();
    #1;
    n_cmp++;
    if ({md_busy, md_done} !== 2'b10) begin n_fail++; $display("FAIL done_to_busy_next: got %b want 10", {md_busy, md_done}); end
    for (int c = 0; c < LAT + 2; c++) begin drive_idle(); tick(); end
  endtask

  task automatic test_redirect_override();
    drive_idle();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd6; id_uses_rs = 1'b1; id_rs = 5'd6; ex_redirect = 1'b1;
    #1;
    n_cmp++;
    if ({ifid_flush, idex_bubble, pc_write_en, ifid_write_en} !== 4'b1111) begin
      n_fail++; $display("FAIL redirect_override: got %b want 1111", {ifid_flush, idex_bubble, pc_write_en, ifid_write_en});
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    int done_seen = 0;
    drive_idle(); ex_md_op = 1'b1; tick();
    drive_idle(); tick();
    drive_idle(); rst_n = 1'b0; tick();
    drive_idle(); rst_n = 1'b1;
    #1;
    n_cmp++;
    if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_abort_busy: got %b want 0", md_busy); end
    for (int c = 0; c < LAT + 4; c++) begin
      if (md_done) done_seen++;
      tick(); drive_idle(); #1;
    end
    n_cmp++;
    if (done_seen !== 0) begin n_fail++; $display("FAIL reset_abort_done: got %0d pulses want 0", done_seen); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_idle();
      rst_n = ($urandom_range(0, 49) != 0);
      id_rs = W'($urandom_range(0, 3)); id_rt = W'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom); id_md_req = 1'($urandom);
      ex_rs = W'($urandom_range(0, 3)); ex_rt = W'($urandom_range(0, 3)); ex_rd = W'($urandom_range(0, 3));
      ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
      ex_md_op = (m_busy_left == 0) && ($urandom_range(0, 3) == 0);
      ex_redirect = ($urandom_range(0, 5) == 0);
      mem_rd = W'($urandom_range(0, 3)); mem_reg_write = 1'($urandom); mem_mem_read = 1'($urandom);
      wb_rd = W'($urandom_range(0, 3)); wb_reg_write = 1'($urandom);
      #1;
      n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL random[%0d]: got %b want %b", i, obs, exp_vec()); end
      tick();
    end
    drive_idle(); rst_n = 1'b1;
    for (int c = 0; c < LAT + 2; c++) begin drive_idle(); tick(); end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    drive_idle(); rst_n = 1'b0; tick();
    drive_idle(); rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({stall_cycles, flush_count} !== 64'd0) begin n_fail++; $display("FAIL perf_reset: got %0d/%0d want 0/0", stall_cycles, flush_count); end
    tick();
    test_load_use();
    test_md_sequence();
    drive_idle(); #1;
    n_cmp++;
    if (stall_cycles !== 32'd5) begin n_fail++; $display("FAIL perf_stalls: got %0d want 5", stall_cycles); end
    for (int k = 0; k < 3; k++) begin drive_idle(); ex_redirect = 1'b1; tick(); drive_idle(); tick(); end
    drive_idle(); #1;
    n_cmp++;
    if (flush_count !== 32'd3) begin n_fail++; $display("FAIL perf_flushes: got %0d want 3", flush_count); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_md_sequence();
    test_back_to_back();
    test_redirect_override();
    test_reset_mid_busy();
    test_random();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sched_ctrl.md
Name: hazard_sched_ctrl

Overview:
Pipeline hazard controller and multi-cycle mult/div scheduler for the 5-stage MIPS core in Top.
- Drives the EX-stage operand forwarding selects.
- Stalls PC and IF/ID, and injects ID/EX bubbles on load-use hazards and on mult/div occupancy.
- Flushes younger instructions on a taken branch or jump resolved in EX.
- Sequences the shared mult/div unit through an IDLE/BUSY/DONE FSM.

Parameters:
REG_ADDR_W, 5, register index width
MD_LATENCY, 4, mult/div execute cycles in BUSY (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active low
id_rs  in  REG_ADDR_W  ID-stage source register 1
id_rt  in  REG_ADDR_W  ID-stage source register 2
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_md_req  in  1  ID instruction is mult/div or reads HI/LO
ex_rs  in  REG_ADDR_W  EX-stage source register 1
ex_rt  in  REG_ADDR_W  EX-stage source register 2
ex_rd  in  REG_ADDR_W  EX-stage destination
ex_reg_write  in  1  EX instruction writes the register file
ex_mem_read  in  1  EX instruction is a load
ex_md_op  in  1  valid mult/div instruction in EX
ex_redirect  in  1  taken branch or jump resolved in EX
mem_rd  in  REG_ADDR_W  EX/MEM destination
mem_reg_write  in  1  EX/MEM writes the register file
mem_mem_read  in  1  EX/MEM is a load
wb_rd  in  REG_ADDR_W  MEM/WB destination
wb_reg_write  in  1  MEM/WB writes the register file
fwd_a  out  2  ALU operand A select: 00 regfile, 01 MEM/WB, 10 EX/MEM
fwd_b  out  2  ALU operand B select, same encoding
pc_write_en  out  1  PC update enable
ifid_write_en  out  1  IF/ID latch enable
ifid_flush  out  1  zero the IF/ID latch
idex_bubble  out  1  load a NOP into ID/EX
md_start  out  1  mult/div unit start pulse
md_busy  out  1  mult/div FSM in BUSY (registered)
md_done  out  1  one-cycle result-valid pulse (registered)

Behaviour:
- Reset: synchronous; sampled on the rising clk edge with rst_n=0.
  - FSM goes to IDLE, counter clears to 0, md_busy=0, md_done=0.
  - While rst_n=0, combinational outputs are forced to: fwd_a=fwd_b=00, pc_write_en=0, ifid_write_en=0, ifid_flush=1, idex_bubble=1, md_start=0.
  - Reset mid-BUSY aborts the operation; no md_done is produced.
- Forwarding (combinational, zero latency):
  - Select 10 when mem_reg_write & !mem_mem_read & mem_rd==ex_rs.
  - Otherwise select 01 when wb_reg_write & wb_rd==ex_rs.
  - Otherwise select 00.
  - fwd_b uses the same rule on ex_rt.
  - EX/MEM takes priority over MEM/WB.
  - Register index 0 is forwarded like any other register; it is not hardwired to zero.
- Load-use stall:
  - Condition: ex_mem_read & ex_reg_write & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - Effect: pc_write_en=0, ifid_write_en=0, idex_bubble=1 for exactly 1 cycle.
- Mult/div stall:
  - Condition: id_md_req while the FSM is in BUSY.
  - Effect: same controls as the load-use stall, held until BUSY exits.
- Redirect:
  - Condition: ex_redirect=1.
  - Effect: ifid_flush=1, idex_bubble=1, pc_write_en=1, ifid_write_en=1.
  - Redirect overrides any stall in the same cycle, because the stalled ID instruction is being killed.
- FSM:
  - IDLE -> BUSY when ex_md_op=1. md_start=1 in that same cycle (combinational). Counter loads MD_LATENCY-1.
  - BUSY: counter decrements each cycle; md_busy=1; moves to DONE when counter==0. BUSY therefore lasts MD_LATENCY cycles.
  - DONE: md_done=1 for 1 cycle; next state IDLE.
  - ex_md_op=1 while in DONE is accepted: DONE -> BUSY directly, with md_start=1.
  - ex_md_op=1 while in BUSY cannot occur, because the ID stall prevents it. If it is asserted anyway, it is ignored; simulation asserts an error.
- A redirect never cancels an in-flight mult/div: the mult/div is older than the redirect.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds 32-bit output ports stall_cycles and flush_count.
  - Both reset to 0 and wrap modulo 2^32.
  - stall_cycles increments on every cycle with pc_write_en=0 and rst_n=1.
  - flush_count increments on every cycle with ex_redirect=1.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
1. mem_reg_write=1, mem_rd=3, wb_reg_write=1, wb_rd=3, ex_rs=3, ex_rt=4 -> fwd_a=10, fwd_b=00. Repeat with mem_mem_read=1 -> fwd_a=01.
2. ex_mem_read=1, ex_reg_write=1, ex_rd=5; ID id_uses_rt=1, id_rt=5 -> one cycle with pc_write_en=0, ifid_write_en=0, idex_bubble=1. Next cycle (ex_mem_read=0) -> all run values.
3. ex_md_op pulse, MD_LATENCY=4, then id_md_req held high -> md_start same cycle; md_busy high 4 cycles; pc_write_en low those 4 cycles; md_done pulses on cycle 5; pipeline resumes.
4. Load-use condition and ex_redirect=1 in the same cycle -> ifid_flush=1, idex_bubble=1, pc_write_en=1.
5. rst_n=0 asserted for 1 cycle during BUSY (counter at 2) -> md_busy=0 next cycle; no md_done ever; FSM in IDLE.
6. HAZARD_PERF_EN defined: run scenarios 2 and 3 -> stall_cycles=5; three redirect pulses -> flush_count=3.
